odd_seq_checker: RTL and testbench

- Downstream consumer of the odd counter's count output, sampled on the same clock.
- Checks that the incoming value follows the odd sequence 1,3,5,…,(2^WIDTH−1),1,… and locks onto it after LOCK_CNT consecutive good samples.
- Flags and counts sequence breaks while locked, and pulses once per completed period (wrap to 1).
- Used as the self-checking monitor stage behind the counter in system and bench builds.

---
 rtl/odd_seq_checker.sv | 167 ++++++++++++++++
 tb/tb_odd_seq_checker.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/odd_seq_checker.sv
// odd_seq_checker
//
// Monitor stage that sits behind the odd counter on the same clock. It checks
// that the sampled count follows 1,3,5,...,(2^WIDTH-1),1,... It locks onto the
// sequence after LOCK_CNT consecutive in-sequence samples. While locked it
// flags and counts sequence breaks, and it pulses once per completed period.
//
// Ports:
//   clk          system clock, all state changes on the rising edge
//   reset        asynchronous active-low reset (0 = reset asserted)
//   count        value from the upstream odd counter
//   count_valid  count is only sampled while this is high
//   locked       high while the checker is in the LOCKED state
//   err          one-cycle pulse on a sequence break while locked
//   err_count    number of breaks since reset, saturates at all-ones
//   period_done  one-cycle pulse when a locked sample wraps to 1
//   expected     next value the checker expects, 0 while searching
//
// Every output is driven directly from a flop. The response to a sample
// appears in the cycle after the edge that samples it.

module odd_seq_checker #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count,
  input  logic             count_valid,
  output logic             locked,
  output logic             err,
  output logic [ERR_W-1:0] err_count,
  output logic             period_done,
  output logic [WIDTH-1:0] expected
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ref_q, ref_d;
  logic [3:0]       run_q, run_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             err_q, err_d;
  logic             pd_q, pd_d;
  logic             locked_q, locked_d;
  logic [WIDTH-1:0] exp_q, exp_d;

  logic [WIDTH-1:0] ref_next;
  logic [3:0]       run_inc;
  logic             match;
  logic             is_odd;
  logic             is_one;

  // The +2 step wraps naturally modulo 2^WIDTH, so 2^WIDTH-1 is followed by 1.
  assign ref_next = ref_q + WIDTH'(2);
  assign run_inc  = run_q + 4'd1;
  assign match    = (count == ref_next);
  assign is_odd   = count[0];
  assign is_one   = (count == WIDTH'(1));

  // State and all output flops. Reset clears everything at once, without
  // waiting for a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= SEARCH;
      ref_q     <= '0;
      run_q     <= '0;
      err_cnt_q <= '0;
      err_q     <= 1'b0;
      pd_q      <= 1'b0;
      locked_q  <= 1'b0;
      exp_q     <= '0;
    end else begin
      state_q   <= state_d;
      ref_q     <= ref_d;
      run_q     <= run_d;
      err_cnt_q <= err_cnt_d;
      err_q     <= err_d;
      pd_q      <= pd_d;
      locked_q  <= locked_d;
      exp_q     <= exp_d;
    end
  end

  // Next-state logic. Without a valid sample everything holds and the two
  // pulse outputs drop. In LOCKED a mismatch always wins over the wrap
  // detection, so a bad jump to 1 never reports a completed period.
  always_comb begin
    state_d   = state_q;
    ref_d     = ref_q;
    run_d     = run_q;
    err_cnt_d = err_cnt_q;
    err_d     = 1'b0;
    pd_d      = 1'b0;

    if (count_valid) begin
      case (state_q)
        SEARCH: begin
          if (is_odd) begin
            ref_d   = count;
            run_d   = 4'd1;
            state_d = TRACK;
          end
        end

        TRACK: begin
          if (match) begin
            ref_d = count;
            run_d = run_inc;
            if (run_inc == 4'(LOCK_CNT)) begin
              state_d = LOCKED;
            end
          end else if (is_odd) begin
            ref_d = count;
            run_d = 4'd1;
          end else begin
            run_d   = '0;
            state_d = SEARCH;
          end
        end

        LOCKED: begin
          if (match) begin
            ref_d = count;
            pd_d  = is_one;
          end else begin
            err_d = 1'b1;
            if (err_cnt_q != '1) begin
              err_cnt_d = err_cnt_q + ERR_W'(1);
            end
            if (is_odd) begin
              ref_d   = count;
              run_d   = 4'd1;
              state_d = TRACK;
            end else begin
              run_d   = '0;
              state_d = SEARCH;
            end
          end
        end

        default: begin
          ref_d   = '0;
          run_d   = '0;
          state_d = SEARCH;
        end
      endcase
    end

    // The status outputs are precomputed from the next state so they can be
    // registered without adding a cycle of latency.
    locked_d = (state_d == LOCKED);
    exp_d    = (state_d == SEARCH) ? '0 : (ref_d + WIDTH'(2));
  end

  assign locked      = locked_q;
  assign err         = err_q;
  assign err_count   = err_cnt_q;
  assign period_done = pd_q;
  assign expected    = exp_q;

endmodule

// File: tb/tb_odd_seq_checker.sv
// Testbench for odd_seq_checker using default parameters (WIDTH=4, LOCK_CNT=3,
// ERR_W=8). The stimulus process pushes the hand-computed response for each
// sample into a scoreboard queue. A separate monitor pops and compares one
// entry per clock, just after the edge that produced the response.

module tb_odd_seq_checker;

  typedef struct packed {
    logic       locked;
    logic       err;
    logic [7:0] err_count;
    logic       period_done;
    logic [3:0] expected;
  } resp_t;

  logic       clk;
  logic       reset;
  logic [3:0] count;
  logic       count_valid;
  logic       locked;
  logic       err;
  logic [7:0] err_count;
  logic       period_done;
  logic [3:0] expected;

  resp_t sb[$];
  string sb_name[$];
  int    tests    = 0;
  int    failures = 0;

  odd_seq_checker dut (
    .clk        (clk),
    .reset      (reset),
    .count      (count),
    .count_valid(count_valid),
    .locked     (locked),
    .err        (err),
    .err_count  (err_count),
    .period_done(period_done),
    .expected   (expected)
  );

  // Free-running 10-time-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic resp_t r(input logic l, input logic e, input int ec,
                              input logic pd, input int ex);
    resp_t v;
    v.locked      = l;
    v.err         = e;
    v.err_count   = 8'(ec);
    v.period_done = pd;
    v.expected    = 4'(ex);
    return v;
  endfunction

  // Compares the DUT outputs against one expected response
  task automatic checkOutput(input string name, input resp_t want);
    resp_t got;
    got.locked      = locked;
    got.err         = err;
    got.err_count   = err_count;
    got.period_done = period_done;
    got.expected    = expected;
    tests++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s: got locked=%0b err=%0b err_count=%0d period_done=%0b expected=%0d, want locked=%0b err=%0b err_count=%0d period_done=%0b expected=%0d",
               name, got.locked, got.err, got.err_count, got.period_done, got.expected,
               want.locked, want.err, want.err_count, want.period_done, want.expected);
    end
  endtask

  // Drives one sample on the falling edge and queues its expected response
  task automatic applyStimulus(input string name, input int c, input logic v,
                               input resp_t want);
    @(negedge clk);
    count       = 4'(c);
    count_valid = v;
    sb.push_back(want);
    sb_name.push_back(name);
  endtask

  // Waits, with a bound, until the monitor has consumed every queued response
  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #2;
    tests++;
    if (sb.size() != 0) begin
      failures++;
      $display("[TB] FAIL drain: got %0d responses pending, want 0", sb.size());
    end
  endtask

  // Monitor: one response per clock, sampled just after the rising edge
  initial begin
    resp_t e;
    string n;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        n = sb_name.pop_front();
        checkOutput(n, e);
      end
    end
  end

  initial begin
    int ec;
    reset       = 1'b1;
    count       = 4'd0;
    count_valid = 1'b0;

    // Asynchronous reset with the count bus toggling: outputs must be clear
    // immediately and stay clear until release.
    #2 reset = 1'b0;
    #1 checkOutput("reset_async", r(0, 0, 0, 0, 0));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      count       = (i == 0) ? 4'd5 : 4'd1;
      count_valid = 1'b1;
      @(posedge clk);
      #1 checkOutput("reset_hold", r(0, 0, 0, 0, 0));
    end
    @(negedge clk);
    reset       = 1'b1;
    count_valid = 1'b0;

    // Lock onto 1,3,5
    applyStimulus("lock_1", 1, 1, r(0, 0, 0, 0, 3));
    applyStimulus("lock_3", 3, 1, r(0, 0, 0, 0, 5));
    applyStimulus("lock_5", 5, 1, r(1, 0, 0, 0, 7));

    // Full period through the 15 -> 1 wrap
    applyStimulus("wrap_7",  7,  1, r(1, 0, 0, 0, 9));
    applyStimulus("wrap_9",  9,  1, r(1, 0, 0, 0, 11));
    applyStimulus("wrap_11", 11, 1, r(1, 0, 0, 0, 13));
    applyStimulus("wrap_13", 13, 1, r(1, 0, 0, 0, 15));
    applyStimulus("wrap_15", 15, 1, r(1, 0, 0, 0, 1));
    applyStimulus("wrap_1",  1,  1, r(1, 0, 0, 1, 3));
    applyStimulus("wrap_3",  3,  1, r(1, 0, 0, 0, 5));
    applyStimulus("wrap_5",  5,  1, r(1, 0, 0, 0, 7));

    // Upstream reset jumps to 1 while 7 is expected: a break, no period_done
    applyStimulus("break_1", 1, 1, r(0, 1, 1, 0, 3));
    applyStimulus("break_3", 3, 1, r(0, 0, 1, 0, 5));
    applyStimulus("break_5", 5, 1, r(1, 0, 1, 0, 7));

    // Even glitch drops to SEARCH; an even sample keeps it there; an odd
    // mismatch in TRACK restarts the run from the new value.
    applyStimulus("even_4",    4,  1, r(0, 1, 2, 0, 0));
    applyStimulus("search_2",  2,  1, r(0, 0, 2, 0, 0));
    applyStimulus("relock_1",  1,  1, r(0, 0, 2, 0, 3));
    applyStimulus("track_7",   7,  1, r(0, 0, 2, 0, 9));
    applyStimulus("track_9",   9,  1, r(0, 0, 2, 0, 11));
    applyStimulus("relock_11", 11, 1, r(1, 0, 2, 0, 13));

    // Valid gating: garbage counts while count_valid is low change nothing
    for (int i = 0; i < 10; i++) begin
      applyStimulus("gated", (i * 7 + 2) % 16, 0, r(1, 0, 2, 0, 13));
    end

    // Repeated breaks saturate the error counter at 255
    for (int i = 0; i < 260; i++) begin
      ec = (3 + i > 255) ? 255 : 3 + i;
      applyStimulus("sat_break", 1, 1, r(0, 1, ec, 0, 3));
      applyStimulus("sat_3",     3, 1, r(0, 0, ec, 0, 5));
      applyStimulus("sat_5",     5, 1, r(1, 0, ec, 0, 7));
    end
    drain();

    // Reset asserted between edges clears everything immediately
    @(posedge clk);
    #2 reset = 1'b0;
    #1 checkOutput("reset_mid", r(0, 0, 0, 0, 0));
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      count       = (i == 0) ? 4'd7 : 4'd9;
      count_valid = 1'b1;
      @(posedge clk);
      #1 checkOutput("reset_mid_hold", r(0, 0, 0, 0, 0));
    end
    @(negedge clk);
    reset       = 1'b1;
    count_valid = 1'b0;

    applyStimulus("post_1", 1, 1, r(0, 0, 0, 0, 3));
    applyStimulus("post_3", 3, 1, r(0, 0, 0, 0, 5));
    applyStimulus("post_5", 5, 1, r(1, 0, 0, 0, 7));
    applyStimulus("post_7", 7, 1, r(1, 0, 0, 0, 9));
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
